math_adder_brent_kung_pipe_032: RTL and testbench

- Two-stage pipelined 32-bit Brent-Kung adder with a valid/ready handshake.
- Stage A takes in operands and carry-in, computes bitwise propagate/generate, and registers it.
- Between A and B, the existing combinational group-PG prefix network (math_adder_brent_kung_grouppg_032) turns that into carries.
- Stage B registers sum and carry-out. This block is the upstream PG source and downstream sum consumer wrapped around the prefix tree, for datapaths that need a registered, back-pressurable adder.

---
 rtl/math_adder_brent_kung_pipe_032_pkg.sv | 22 ++
 rtl/math_adder_brent_kung_bitwisepg.sv | 23 ++
 rtl/math_adder_brent_kung_grouppg_032.sv | 64 ++++++
 rtl/math_adder_brent_kung_pipe_032.sv | 107 ++++++++++
 tb/tb_math_adder_brent_kung_pipe_032.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/math_adder_brent_kung_pipe_032_pkg.sv
// ============================================================================
// math_adder_brent_kung_pipe_032_pkg
// Shared widths and a level-count helper for the 32-bit Brent-Kung adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package math_adder_brent_kung_pipe_032_pkg;

    localparam int BK_WIDTH = 32;
    localparam int BK_NPG   = BK_WIDTH + 1;

    function automatic int bk_levels(input int w);
        int lv;
        lv = 0;
        while ((1 << lv) < w) lv++;
        return lv;
    endfunction

endpackage

`default_nettype wire

// File: rtl/math_adder_brent_kung_bitwisepg.sv
// ============================================================================
// math_adder_brent_kung_bitwisepg
// Bitwise propagate/generate; slot 0 carries the carry-in as a generate.
// Revision: 1.0
// ============================================================================
`default_nettype none

module math_adder_brent_kung_bitwisepg #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N:0]   o_p,
    output logic [N:0]   o_g
);

    assign o_p = {i_a ^ i_b, 1'b0};
    assign o_g = {i_a & i_b, i_cin};

endmodule

`default_nettype wire

// File: rtl/math_adder_brent_kung_grouppg_032.sv
// ============================================================================
// math_adder_brent_kung_grouppg_032
// Brent-Kung prefix tree over 33 PG slots; o_gg[k] is the carry into bit k.
// Revision: 1.0
// ============================================================================
`default_nettype none

module math_adder_brent_kung_grouppg_032
    import math_adder_brent_kung_pipe_032_pkg::*;
(
    input  logic [BK_NPG-1:0] i_p,
    input  logic [BK_NPG-1:0] i_g,
    output logic [BK_NPG-1:0] o_gg
);

    localparam int W = BK_NPG;
    localparam int L = bk_levels(W);

    logic [W-1:0] w_up_p [0:L];
    logic [W-1:0] w_up_g [0:L];
    logic [W-1:0] w_dn_p [0:L-1];
    logic [W-1:0] w_dn_g [0:L-1];

    assign w_up_p[0] = i_p;
    assign w_up_g[0] = i_g;

    // Up-sweep: node i absorbs its left neighbour span when i+1 is a multiple of 2^(l+1).
    for (genvar l = 0; l < L; l++) begin : g_up
        for (genvar i = 0; i < W; i++) begin : g_bit
            if (((i + 1) % (2 ** (l + 1))) == 0) begin : g_node
                localparam int J = i - 2 ** l;
                assign w_up_g[l+1][i] = w_up_g[l][i] | (w_up_p[l][i] & w_up_g[l][J]);
                assign w_up_p[l+1][i] = w_up_p[l][i] & w_up_p[l][J];
            end else begin : g_pass
                assign w_up_g[l+1][i] = w_up_g[l][i];
                assign w_up_p[l+1][i] = w_up_p[l][i];
            end
        end
    end

    assign w_dn_p[0] = w_up_p[L];
    assign w_dn_g[0] = w_up_g[L];

    // Down-sweep fills the remaining prefixes from already-complete spans.
    for (genvar d = 0; d < L - 1; d++) begin : g_dn
        localparam int LV = L - 2 - d;
        localparam int S  = 2 ** (LV + 1);
        localparam int H  = 2 ** LV;
        for (genvar i = 0; i < W; i++) begin : g_bit
            if ((i >= S) && (((i + 1) % S) == H)) begin : g_node
                assign w_dn_g[d+1][i] = w_dn_g[d][i] | (w_dn_p[d][i] & w_dn_g[d][i-H]);
                assign w_dn_p[d+1][i] = w_dn_p[d][i] & w_dn_p[d][i-H];
            end else begin : g_pass
                assign w_dn_g[d+1][i] = w_dn_g[d][i];
                assign w_dn_p[d+1][i] = w_dn_p[d][i];
            end
        end
    end

    assign o_gg = w_dn_g[L-1];

endmodule

`default_nettype wire

// File: rtl/math_adder_brent_kung_pipe_032.sv
// ============================================================================
// math_adder_brent_kung_pipe_032
// Two-stage valid/ready pipelined 32-bit Brent-Kung adder (PG reg, sum reg).
// Revision: 1.0
// ============================================================================
`default_nettype none

module math_adder_brent_kung_pipe_032
    import math_adder_brent_kung_pipe_032_pkg::*;
#(
    parameter int N = BK_WIDTH
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    localparam int NPG = N + 1;

    if (N != BK_WIDTH) begin : g_width_check
        $error("math_adder_brent_kung_pipe_032 supports only N == 32");
    end

    logic [NPG-1:0] w_p;
    logic [NPG-1:0] w_g;
    logic [NPG-1:0] w_gg;
    logic           w_ready_a;
    logic           w_ready_b;

    logic           va_q, va_d;
    logic           vb_q, vb_d;
    logic [NPG-1:0] pa_q, pa_d;
    logic [NPG-1:0] ga_q, ga_d;
    logic [N-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;

    math_adder_brent_kung_bitwisepg #(.N(N)) u_bitwisepg (
        .i_a   (i_a),
        .i_b   (i_b),
        .i_cin (i_cin),
        .o_p   (w_p),
        .o_g   (w_g)
    );

    math_adder_brent_kung_grouppg_032 u_grouppg (
        .i_p  (pa_q),
        .i_g  (ga_q),
        .o_gg (w_gg)
    );

    // No skid buffer: upstream ready is a combinational function of i_ready.
    assign w_ready_b = ~vb_q | i_ready;
    assign w_ready_a = ~va_q | w_ready_b;
    assign o_ready   = w_ready_a;

    always_comb begin
        va_d   = va_q;
        pa_d   = pa_q;
        ga_d   = ga_q;
        vb_d   = vb_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        if (w_ready_a) begin
            va_d = i_valid;
            pa_d = w_p;
            ga_d = w_g;
        end
        if (w_ready_b) begin
            vb_d   = va_q;
            sum_d  = pa_q[NPG-1:1] ^ w_gg[N-1:0];
            cout_d = w_gg[N];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            va_q   <= 1'b0;
            pa_q   <= '0;
            ga_q   <= '0;
            vb_q   <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            va_q   <= va_d;
            pa_q   <= pa_d;
            ga_q   <= ga_d;
            vb_q   <= vb_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign o_valid = vb_q;
    assign o_sum   = sum_q;
    assign o_cout  = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_math_adder_brent_kung_pipe_032.sv
// ============================================================================
// tb_math_adder_brent_kung_pipe_032
// Scoreboard bench: a+b+cin reference queue checked against the pipelined adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_math_adder_brent_kung_pipe_032;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic        ready_o;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        ovalid;
    logic        iready = 1'b1;
    logic [31:0] sum;
    logic        cout;

    math_adder_brent_kung_pipe_032 #(.N(32)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid),
        .o_ready (ready_o),
        .i_a     (a),
        .i_b     (b),
        .i_cin   (cin),
        .o_valid (ovalid),
        .i_ready (iready),
        .o_sum   (sum),
        .o_cout  (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s;
        logic        c;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] log_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    bit          strict = 0;
    bit          capture = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_sum = '0;
    logic        prev_cout = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic mc, input int mcyc);
        exp_t        e;
        logic [32:0] t;
        t     = {1'b0, ma} + {1'b0, mb} + {32'd0, mc};
        e.s   = t[31:0];
        e.c   = t[32];
        e.cyc = mcyc;
        return e;
    endfunction

    // Drive one cycle of inputs at the falling edge, then check the settled outputs.
    task automatic step(input bit v, input logic [31:0] va, input logic [31:0] vb,
                        input bit vc, input bit rdy, output bit acc);
        @(negedge clk);
        valid  = v;
        a      = va;
        b      = vb;
        cin    = vc;
        iready = rdy;
        #1;
        cyc++;
        chk("o_ready", {63'd0, ready_o}, (q.size() >= 2 && !rdy) ? 64'd0 : 64'd1);
        chk("no_spurious_valid", {63'd0, ovalid && q.size() == 0}, 64'd0);
        if (strict)
            chk("latency2", {63'd0, ovalid}, {63'd0, q.size() > 0 && q[0].cyc + 2 == cyc});
        if (prev_stall) begin
            chk("stall_hold_sum", {32'd0, sum}, {32'd0, prev_sum});
            chk("stall_hold_cout", {63'd0, cout}, {63'd0, prev_cout});
            chk("stall_hold_valid", {63'd0, ovalid}, 64'd1);
        end
        if (ovalid && q.size() > 0) begin
            chk("sum", {32'd0, sum}, {32'd0, q[0].s});
            chk("cout", {63'd0, cout}, {63'd0, q[0].c});
            if (rdy) begin
                if (capture) log_q.push_back(sum);
                void'(q.pop_front());
            end
        end
        acc = v && ready_o;
        if (acc) q.push_back(model(va, vb, vc, cyc));
        prev_stall = ovalid && !rdy;
        prev_sum   = sum;
        prev_cout  = cout;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int k;
        int r;
        int acc_n;
        int guard;

        rst = 1'b1;
        #3;
        chk("reset_valid", {63'd0, ovalid}, 64'd0);
        chk("reset_sum", {32'd0, sum}, 64'd0);
        chk("reset_cout", {63'd0, cout}, 64'd0);
        chk("reset_ready", {63'd0, ready_o}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic add, then the full carry chain cases.
        strict = 1;
        step(1'b1, 32'd3, 32'd5, 1'b0, 1'b1, acc);
        idle(2);
        chk("basic_valid", {63'd0, ovalid}, 64'd1);
        chk("basic_sum", {32'd0, sum}, 64'h8);
        chk("basic_cout", {63'd0, cout}, 64'd0);

        step(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, acc);
        step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, acc);
        idle(1);
        chk("carry1_sum", {32'd0, sum}, 64'h0);
        chk("carry1_cout", {63'd0, cout}, 64'd1);
        idle(1);
        chk("carry2_sum", {32'd0, sum}, 64'hFFFF_FFFF);
        chk("carry2_cout", {63'd0, cout}, 64'd1);
        idle(2);

        for (int i = 0; i < 1000; i++)
            step(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, acc);
        idle(3);
        chk("throughput_drained", 64'(q.size()), 64'd0);
        strict = 0;

        // Back-pressure: downstream stalls for relative cycles 2..5.
        capture = 1;
        log_q.delete();
        k = 0;
        r = 0;
        while ((k < 4 || q.size() > 0) && r < 30) begin
            step(k < 4, 32'(k + 1), 32'(k + 1), 1'b0, !(r >= 2 && r <= 5), acc);
            if (acc) k++;
            if (r == 3) begin
                chk("bp_ready_low", {63'd0, ready_o}, 64'd0);
                chk("bp_hold_sum", {32'd0, sum}, 64'h2);
            end
            r++;
        end
        capture = 0;
        chk("bp_count", 64'(log_q.size()), 64'd4);
        for (int j = 0; j < 4 && j < log_q.size(); j++)
            chk("bp_order", {32'd0, log_q[j]}, 64'(2 * (j + 1)));

        // Asynchronous reset with both stages occupied.
        step(1'b1, 32'd1, 32'd2, 1'b0, 1'b1, acc);
        step(1'b1, 32'd3, 32'd4, 1'b0, 1'b1, acc);
        @(negedge clk);
        valid  = 1'b0;
        iready = 1'b0;
        #1;
        chk("pre_reset_valid", {63'd0, ovalid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_valid", {63'd0, ovalid}, 64'd0);
        chk("async_reset_sum", {32'd0, sum}, 64'd0);
        chk("async_reset_cout", {63'd0, cout}, 64'd0);
        chk("async_reset_ready", {63'd0, ready_o}, 64'd1);
        q.delete();
        prev_stall = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        strict = 1;
        step(1'b1, 32'd7, 32'd9, 1'b0, 1'b1, acc);
        idle(2);
        chk("post_reset_valid", {63'd0, ovalid}, 64'd1);
        chk("post_reset_sum", {32'd0, sum}, 64'h10);
        idle(1);
        strict = 0;

        // Random valid and ready.
        acc_n = 0;
        guard = 0;
        while (acc_n < 10000 && guard < 60000) begin
            step(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), acc);
            if (acc) acc_n++;
            guard++;
        end
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            idle(1);
            guard++;
        end
        chk("random_beats", 64'(acc_n), 64'd10000);
        chk("random_drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
